// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: return-pipe tags and the
// width of the fetch starvation counter.
package arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } tag_e;

    localparam int WAIT_CNT_W = 3;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: fetch (read-only) and
// data (load/store) request channels plus the shared read-return path.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Handshake: a requester raises req with its payload and holds both
    // stable until gnt; a transfer happens in any cycle with req && gnt.
    // gnt is combinational from req, and dropping req before gnt is legal.
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        input  f_gnt, f_rvalid, d_gnt, d_rvalid, rdata
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        output f_gnt, f_rvalid, d_gnt, d_rvalid, rdata
    );

endinterface

// File: rtl/mem_return_pipe.sv
// Shift register of read-return tags; the head tag emerges exactly DEPTH
// cycles after it was issued and the whole pipe clears asynchronously.
module mem_return_pipe
    import arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_e i_tag,
    output tag_e o_head
);

    tag_e r_stage [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_head = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch wins a conflict
// once it has been denied MAX_WAIT cycles in a row. Read data is steered back by tag.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  mem_wren,
    input  logic [DATA_W-1:0]     mem_q,
    output logic [WAIT_CNT_W-1:0] o_dbg_wait_cnt
);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0]     r_last_addr;
    logic                  w_starve;
    logic                  w_f_gnt;
    logic                  w_d_gnt;
    tag_e                  w_issue_tag;
    tag_e                  w_head_tag;

    assign w_starve = (MAX_WAIT != 0) && (int'(r_wait_cnt) >= MAX_WAIT);

    always_comb begin
        w_f_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_issue_tag = TAG_NONE;
        if (!reset) begin
            if (bus.d_req && !(bus.f_req && w_starve)) begin
                w_d_gnt = 1'b1;
            end else if (bus.f_req) begin
                w_f_gnt = 1'b1;
            end
        end
        if (w_d_gnt && !bus.d_we) begin
            w_issue_tag = TAG_DATA;
        end else if (w_f_gnt) begin
            w_issue_tag = TAG_FETCH;
        end
    end

    // Idle cycles replay the last address so the macro's address pins stay quiet.
    always_comb begin
        mem_address = r_last_addr;
        if (w_d_gnt) begin
            mem_address = bus.d_addr;
        end else if (w_f_gnt) begin
            mem_address = bus.f_addr;
        end
    end

    assign mem_data = bus.d_wdata;
    assign mem_wren = w_d_gnt && bus.d_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_addr <= '0;
        end else if (w_d_gnt) begin
            r_last_addr <= bus.d_addr;
        end else if (w_f_gnt) begin
            r_last_addr <= bus.f_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (bus.f_req && !w_f_gnt) begin
            if (r_wait_cnt != WAIT_CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    mem_return_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_return_pipe (
        .clock  (clock),
        .reset  (reset),
        .i_tag  (w_issue_tag),
        .o_head (w_head_tag)
    );

    assign bus.f_gnt    = w_f_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.f_rvalid = (w_head_tag == TAG_FETCH);
    assign bus.d_rvalid = (w_head_tag == TAG_DATA);
    assign bus.rdata    = mem_q;

    assign o_dbg_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 / guard 4 and
// latency 3 / guard off) share one stimulus stream and a behavioural model.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int RL0 = 1;
    localparam int MW0 = 4;
    localparam int RL1 = 3;
    localparam int MW1 = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          t_f_req = 1'b0;
    logic [AW-1:0] t_f_addr = '0;
    logic          t_d_req = 1'b0;
    logic          t_d_we = 1'b0;
    logic [AW-1:0] t_d_addr = '0;
    logic [DW-1:0] t_d_wdata = '0;
    logic [DW-1:0] t_mem_q = '0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    assign b0.f_req = t_f_req;   assign b1.f_req = t_f_req;
    assign b0.f_addr = t_f_addr; assign b1.f_addr = t_f_addr;
    assign b0.d_req = t_d_req;   assign b1.d_req = t_d_req;
    assign b0.d_we = t_d_we;     assign b1.d_we = t_d_we;
    assign b0.d_addr = t_d_addr; assign b1.d_addr = t_d_addr;
    assign b0.d_wdata = t_d_wdata; assign b1.d_wdata = t_d_wdata;

    logic [AW-1:0]         ma0, ma1;
    logic [DW-1:0]         md0, md1;
    logic                  mw0, mw1;
    logic [WAIT_CNT_W-1:0] wc0, wc1;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL0), .MAX_WAIT(MW0)) dut0 (
        .clock(clock), .reset(reset), .bus(b0),
        .mem_address(ma0), .mem_data(md0), .mem_wren(mw0), .mem_q(t_mem_q),
        .o_dbg_wait_cnt(wc0)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL1), .MAX_WAIT(MW1)) dut1 (
        .clock(clock), .reset(reset), .bus(b1),
        .mem_address(ma1), .mem_data(md1), .mem_wren(mw1), .mem_q(t_mem_q),
        .o_dbg_wait_cnt(wc1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Behavioural reference: returns are booked in a calendar indexed by
    // the cycle in which they are due, wait count is a plain integer.
    int      cyc = 0;
    int      m_wc [2];
    int      m_last [2];
    bit      m_fv [2][8];
    bit      m_dv [2][8];
    bit      m_gd [2];
    bit      m_gf [2];

    function automatic int rl_of(input int k);
        return (k == 0) ? RL0 : RL1;
    endfunction

    function automatic int mw_of(input int k);
        return (k == 0) ? MW0 : MW1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_wc[k] = 0;
            m_last[k] = 0;
            m_gd[k] = 0;
            m_gf[k] = 0;
            for (int s = 0; s < 8; s++) begin
                m_fv[k][s] = 0;
                m_dv[k][s] = 0;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            bit st;
            int e_addr;
            st = (mw_of(k) != 0) && (m_wc[k] >= mw_of(k));
            m_gd[k] = !reset && t_d_req && !(t_f_req && st);
            m_gf[k] = !reset && !m_gd[k] && t_f_req;
            e_addr = m_gd[k] ? int'(t_d_addr) : (m_gf[k] ? int'(t_f_addr) : m_last[k]);
            chk("m_f_gnt", k, 32'(k ? b1.f_gnt : b0.f_gnt), 32'(m_gf[k]));
            chk("m_d_gnt", k, 32'(k ? b1.d_gnt : b0.d_gnt), 32'(m_gd[k]));
            chk("m_wren", k, 32'(k ? mw1 : mw0), 32'(m_gd[k] && t_d_we));
            chk("m_addr", k, 32'(k ? ma1 : ma0), 32'(e_addr));
            chk("m_data", k, 32'(k ? md1 : md0), 32'(t_d_wdata));
            chk("m_f_rvalid", k, 32'(k ? b1.f_rvalid : b0.f_rvalid), 32'(!reset && m_fv[k][cyc % 8]));
            chk("m_d_rvalid", k, 32'(k ? b1.d_rvalid : b0.d_rvalid), 32'(!reset && m_dv[k][cyc % 8]));
            chk("m_rdata", k, 32'(k ? b1.rdata : b0.rdata), 32'(t_mem_q));
            chk("m_wait_cnt", k, 32'(k ? wc1 : wc0), 32'(m_wc[k]));
        end
    endtask

    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                int due;
                due = (cyc + rl_of(k)) % 8;
                m_fv[k][cyc % 8] = 0;
                m_dv[k][cyc % 8] = 0;
                if (m_gd[k]) begin
                    m_last[k] = int'(t_d_addr);
                    if (!t_d_we) m_dv[k][due] = 1;
                end else if (m_gf[k]) begin
                    m_last[k] = int'(t_f_addr);
                    m_fv[k][due] = 1;
                end
                if (t_f_req && !m_gf[k]) m_wc[k] = (m_wc[k] < 7) ? m_wc[k] + 1 : 7;
                else m_wc[k] = 0;
            end
        end
        cyc++;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        #1;
        check_model();
        @(posedge clock);
        update_model();
        @(negedge clock);
    endtask

    task automatic set_in(input bit fr, input logic [AW-1:0] fa, input bit dr, input bit we,
                          input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [DW-1:0] q);
        t_f_req = fr; t_f_addr = fa; t_d_req = dr; t_d_we = we;
        t_d_addr = da; t_d_wdata = wd; t_mem_q = q;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        set_in(0, '0, 0, 0, '0, '0, '0);
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit            f_req;
        logic [AW-1:0] f_addr;
        bit            d_req;
        bit            d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [DW-1:0] mem_q;
        bit            e_fg;
        bit            e_dg;
        bit            e_wren;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        bit            e_frv;
        bit            e_drv;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    bit   s_frv [6];
    bit   s_drv [6];
    bit   x_frv [6];
    bit   x_drv [6];

    initial begin
        int n;

        // Directed vectors for dut0 (latency 1, guard 4), applied from reset.
        vt[0]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0010, 16'h0000, 0, 0};
        vt[1]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hC1A0, 0, 0, 0, 16'h0010, 16'h0000, 1, 0};
        vt[2]  = '{0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 16'h0000, 0, 1, 1, 16'h0040, 16'h1234, 0, 0};
        vt[3]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0040, 16'h0000, 0, 0};
        vt[4]  = '{1, 16'h0060, 1, 0, 16'h0050, 16'h0000, 16'h0000, 0, 1, 0, 16'h0050, 16'h0000, 0, 0};
        vt[5]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0050, 16'h0000, 0, 1};
        vt[6]  = '{1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 0, 1, 0, 16'h0200, 16'h0000, 0, 0};
        vt[7]  = '{1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 0, 1, 0, 16'h0200, 16'h0000, 0, 1};
        vt[8]  = '{1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 0, 1, 0, 16'h0200, 16'h0000, 0, 1};
        vt[9]  = '{1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 0, 1, 0, 16'h0200, 16'h0000, 0, 1};
        vt[10] = '{1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 1, 0, 0, 16'h0100, 16'h0000, 0, 1};
        vt[11] = '{1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 0, 1, 0, 16'h0200, 16'h0000, 1, 0};
        vt[12] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0200, 16'h0000, 0, 1};

        x_frv = '{0, 0, 0, 1, 0, 1};
        x_drv = '{0, 0, 0, 0, 1, 0};

        model_clear();
        @(negedge clock);
        #1;
        chk("rst_f_gnt", 0, 32'(b0.f_gnt), 32'd0);
        chk("rst_rvalid", 1, 32'(b1.f_rvalid | b1.d_rvalid), 32'd0);
        chk("rst_addr", 0, 32'(ma0), 32'd0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            set_in(vt[i].f_req, vt[i].f_addr, vt[i].d_req, vt[i].d_we,
                   vt[i].d_addr, vt[i].d_wdata, vt[i].mem_q);
            #1;
            chk($sformatf("vec%0d_f_gnt", i), 0, 32'(b0.f_gnt), 32'(vt[i].e_fg));
            chk($sformatf("vec%0d_d_gnt", i), 0, 32'(b0.d_gnt), 32'(vt[i].e_dg));
            chk($sformatf("vec%0d_wren", i), 0, 32'(mw0), 32'(vt[i].e_wren));
            chk($sformatf("vec%0d_addr", i), 0, 32'(ma0), 32'(vt[i].e_addr));
            chk($sformatf("vec%0d_data", i), 0, 32'(md0), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_f_rvalid", i), 0, 32'(b0.f_rvalid), 32'(vt[i].e_frv));
            chk($sformatf("vec%0d_d_rvalid", i), 0, 32'(b0.d_rvalid), 32'(vt[i].e_drv));
            if (vt[i].e_frv) chk($sformatf("vec%0d_rdata", i), 0, 32'(b0.rdata), 32'(vt[i].mem_q));
            step();
        end

        // Latency-3 ordering: F, D load, F back to back on dut1.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: set_in(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'($urandom));
                1: set_in(0, 16'h0000, 1, 0, 16'h0002, 16'h0000, 16'($urandom));
                2: set_in(1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 16'($urandom));
                default: set_in(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'($urandom));
            endcase
            #1;
            s_frv[c] = b1.f_rvalid;
            s_drv[c] = b1.d_rvalid;
            step();
        end
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rl3_f_rvalid_c%0d", c), 1, 32'(s_frv[c]), 32'(x_frv[c]));
            chk($sformatf("rl3_d_rvalid_c%0d", c), 1, 32'(s_drv[c]), 32'(x_drv[c]));
        end

        // Reset arriving while a fetch is in flight.
        do_reset();
        set_in(1, 16'h0AAA, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step();
        reset = 1'b1;
        model_clear();
        set_in(1, 16'h0BBB, 1, 1, 16'h0CCC, 16'h5555, 16'h0000);
        #1;
        chk("rst_mid_f_gnt", 1, 32'(b1.f_gnt), 32'd0);
        chk("rst_mid_d_gnt", 1, 32'(b1.d_gnt), 32'd0);
        chk("rst_mid_wren", 1, 32'(mw1), 32'd0);
        chk("rst_mid_f_rvalid", 1, 32'(b1.f_rvalid), 32'd0);
        step();
        step();
        reset = 1'b0;
        set_in(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        #1;
        chk("rst_rel_wait_cnt", 0, 32'(wc0), 32'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rst_drop_f_rvalid_c%0d", c), 1, 32'(b1.f_rvalid), 32'd0);
            step();
        end

        // Fetch withdrawn after two denials must restart its count from zero.
        do_reset();
        set_in(1, 16'h0400, 1, 0, 16'h0300, 16'h0000, 16'h0000);
        step();
        step();
        #1;
        chk("wd_wait_cnt_2", 0, 32'(wc0), 32'd2);
        t_f_req = 1'b0;
        step();
        #1;
        chk("wd_wait_cnt_clr", 0, 32'(wc0), 32'd0);
        t_f_req = 1'b1;
        n = 0;
        while (n < 10) begin
            #1;
            chk("wd_dut1_no_f_gnt", 1, 32'(b1.f_gnt), 32'd0);
            if (b0.f_gnt) break;
            n++;
            step();
        end
        chk("wd_denials_before_f_gnt", 0, 32'(n), 32'd4);
        step();

        // Randomised traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            set_in(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
